// File: rtl/prog_ctrl_pkg.sv
// Shared definitions for the program-load / run controller and the
// instruction-ROM load port.
//   INSTR_W      : machine-word width
//   ctrl_state_t : controller phase (LOAD, RELEASE, RUN, HALT)
package prog_ctrl_pkg;

    localparam int INSTR_W = 9;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2,
        HALT    = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/prog_load_ctrl_if.sv
// Loader word stream (valid/ready) between the program source and the
// controller.
//   in_valid : word valid               (master -> slave)
//   in_data  : machine word             (master -> slave)
//   in_last  : final word, with valid   (master -> slave)
//   in_ready : controller accepts word  (slave -> master)
interface prog_load_ctrl_if;
    import prog_ctrl_pkg::*;

    logic               in_valid;
    logic [INSTR_W-1:0] in_data;
    logic               in_last;
    logic               in_ready;

    modport master (output in_valid, output in_data, output in_last, input in_ready);
    modport slave  (input in_valid, input in_data, input in_last, output in_ready);

endinterface

// File: rtl/sat_counter.sv
// Up-counter with enable and synchronous clear. It stops at LIMIT, so it
// can never wrap however long enable stays high.
//   clk   : clock
//   clr_i : synchronous clear (wins over enable)
//   en_i  : count enable
//   cnt_o : current count
module sat_counter #(
    parameter int W     = 8,
    parameter int LIMIT = 255
) (
    input  logic         clk,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != W'(LIMIT))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/prog_load_ctrl.sv
// Run controller for top_level: streams machine words into instruction
// memory, holds the core in reset for RST_CYC cycles, releases it, counts
// execution cycles until done or MAX_CYC, then freezes the core.
//
// state   | meaning
// --------+-----------------------------------------------
// LOAD    | accepting words, writing instruction memory
// RELEASE | load finished, core still held in reset
// RUN     | core running, cycles counting
// HALT    | run ended, core frozen, status held
//
// Ports: clk, reset (sync, active-high); ld (loader stream, slave);
// wr_en/wr_addr/wr_data (memory write port); core_reset/core_done;
// words, cycles, finished, timeout, overflow (status).
module prog_load_ctrl
    import prog_ctrl_pkg::*;
#(
    parameter int D       = 12,
    parameter int RST_CYC = 4,
    parameter int CW      = 16,
    parameter int MAX_CYC = 60000
) (
    input  logic               clk,
    input  logic               reset,
    prog_load_ctrl_if.slave    ld,
    output logic               wr_en,
    output logic [D-1:0]       wr_addr,
    output logic [INSTR_W-1:0] wr_data,
    output logic               core_reset,
    input  logic               core_done,
    output logic [D:0]         words,
    output logic [CW-1:0]      cycles,
    output logic               finished,
    output logic               timeout,
    output logic               overflow
);

    localparam int           RCW      = $clog2(RST_CYC + 1);
    localparam logic [D-1:0] ADDR_MAX = '1;

    ctrl_state_t    state_q, state_d;
    logic [D-1:0]   addr_q, addr_d;
    logic [D:0]     words_q, words_d;
    logic           finished_q, finished_d;
    logic           timeout_q, timeout_d;
    logic           overflow_q, overflow_d;

    logic [RCW-1:0] rst_cnt;
    logic [CW-1:0]  cyc_cnt;
    logic           load_rdy;
    logic           xfer;
    logic           rst_last;
    logic           cyc_last;

    sat_counter #(.W(RCW), .LIMIT(RST_CYC)) u_rst_cnt (
        .clk   (clk),
        .clr_i (reset),
        .en_i  (state_q == RELEASE),
        .cnt_o (rst_cnt)
    );

    // Runs only in RUN, so it stops on the edge that leaves RUN; that
    // edge is still counted, which is what makes the done cycle count.
    sat_counter #(.W(CW), .LIMIT(MAX_CYC)) u_cyc_cnt (
        .clk   (clk),
        .clr_i (reset),
        .en_i  (state_q == RUN),
        .cnt_o (cyc_cnt)
    );

    assign rst_last = (rst_cnt == RCW'(RST_CYC - 1));
    assign cyc_last = (cyc_cnt == CW'(MAX_CYC - 1));

    // Handshake outputs decode state (and the reset cycle) only.
    always_comb begin
        load_rdy    = (state_q == LOAD) && !reset;
        core_reset  = (state_q != RUN) || reset;
        ld.in_ready = load_rdy;
        xfer        = ld.in_valid && load_rdy;
        wr_en       = xfer;
        wr_addr     = addr_q;
        wr_data     = ld.in_data;
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        words_d    = words_q;
        finished_d = finished_q;
        timeout_d  = timeout_q;
        overflow_d = overflow_q;
        case (state_q)
            LOAD: begin
                if (xfer) begin
                    // Hold at the top address rather than wrapping to 0.
                    addr_d  = (addr_q == ADDR_MAX) ? addr_q : addr_q + 1'b1;
                    words_d = words_q + 1'b1;
                    if (ld.in_last) begin
                        state_d = RELEASE;
                    end else if (addr_q == ADDR_MAX) begin
                        overflow_d = 1'b1;
                        state_d    = RELEASE;
                    end
                end
            end
            RELEASE: begin
                if (rst_last) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (core_done) begin
                    state_d    = HALT;
                    finished_d = 1'b1;
                end else if (cyc_last) begin
                    state_d    = HALT;
                    finished_d = 1'b1;
                    timeout_d  = 1'b1;
                end
            end
            HALT: begin
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= LOAD;
            addr_q     <= '0;
            words_q    <= '0;
            finished_q <= 1'b0;
            timeout_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            words_q    <= words_d;
            finished_q <= finished_d;
            timeout_q  <= timeout_d;
            overflow_q <= overflow_d;
        end
    end

    assign words    = words_q;
    assign cycles   = cyc_cnt;
    assign finished = finished_q;
    assign timeout  = timeout_q;
    assign overflow = overflow_q;

endmodule
